// File: rtl/store_block_if.sv
// store_block_if
//   Bundles the request and DMA-write signals of store_block.
//   Request side : enable, size, address, blockIn (driven by the controller)
//   Status side  : busy, done
//   DMA side     : dmaEnable, rw, dmaAddress, dmaData (driven by store_block)
//   modport master : the controller / DMA environment
//   modport slave  : store_block itself
interface store_block_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WORDS  = 1024
);
    logic                            enable;
    logic [15:0]                     size;
    logic [ADDR_WIDTH-1:0]           address;
    logic [MAX_WORDS*DATA_WIDTH-1:0] blockIn;
    logic                            dmaEnable;
    logic                            rw;
    logic [ADDR_WIDTH-1:0]           dmaAddress;
    logic [DATA_WIDTH-1:0]           dmaData;
    logic                            busy;
    logic                            done;

    modport master (
        output enable, size, address, blockIn,
        input  dmaEnable, rw, dmaAddress, dmaData, busy, done
    );

    modport slave (
        input  enable, size, address, blockIn,
        output dmaEnable, rw, dmaAddress, dmaData, busy, done
    );
endinterface

// File: rtl/store_block.sv
// store_block
//   Writes a size x size block of result words (row-major) from the flattened
//   result buffer to memory, one DMA write per cycle, then raises done until
//   enable is released.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low
//   bus    : store_block_if.slave
//            enable/size/address/blockIn in, dmaEnable/rw/dmaAddress/dmaData/
//            busy/done out (all outputs registered)
module store_block #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WORDS  = 1024
) (
    input  logic         clk,
    input  logic         reset,
    store_block_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int BIT_W = $clog2(MAX_WORDS * DATA_WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic                  dma_en_q, dma_en_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [CNT_W-1:0]      total_new;
    logic [CNT_W-1:0]      idx_sel;
    logic [BIT_W-1:0]      bit_base;
    logic [DATA_WIDTH-1:0] word_sel;

    // Clamp the 32-bit word count to the buffer capacity so the index can
    // never run past the end of blockIn.
    function automatic logic [CNT_W-1:0] sat_total(input logic [31:0] words);
        if (words > 32'(MAX_WORDS)) begin
            return CNT_W'(MAX_WORDS);
        end
        return CNT_W'(words);
    endfunction

    // Word 0 is issued straight out of IDLE, so the word selector only
    // follows idx_q while writing.
    assign idx_sel  = (state_q == WRITE) ? idx_q : '0;
    assign bit_base = BIT_W'(idx_sel) * BIT_W'(DATA_WIDTH);
    assign word_sel = bus.blockIn[bit_base +: DATA_WIDTH];

    assign total_new = sat_total(32'(bus.size) * 32'(bus.size));

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        total_d  = total_q;
        idx_d    = idx_q;
        dma_en_d = 1'b0;
        rw_d     = 1'b1;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (bus.enable) begin
                    base_d  = bus.address;
                    total_d = total_new;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    if (total_new == '0) begin
                        state_d = DONE;
                    end else begin
                        // Issue word 0 on the accepting edge so the first
                        // write is visible one cycle after enable is sampled;
                        // idx then points at the next word to issue.
                        dma_en_d = 1'b1;
                        rw_d     = 1'b0;
                        addr_d   = bus.address;
                        data_d   = word_sel;
                        idx_d    = CNT_W'(1);
                        state_d  = (total_new == CNT_W'(1)) ? DONE : WRITE;
                    end
                end
            end
            WRITE: begin
                dma_en_d = 1'b1;
                rw_d     = 1'b0;
                // Address arithmetic is truncated to ADDR_WIDTH: wraps silently.
                addr_d   = base_q + ADDR_WIDTH'(idx_q);
                data_d   = word_sel;
                idx_d    = idx_q + CNT_W'(1);
                if (idx_q == total_q - CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                // done is shown for at least one cycle even if enable has
                // already dropped, so completion is never missed.
                if (done_q && !bus.enable) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            total_q  <= '0;
            idx_q    <= '0;
            dma_en_q <= 1'b0;
            rw_q     <= 1'b1;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            total_q  <= total_d;
            idx_q    <= idx_d;
            dma_en_q <= dma_en_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.dmaEnable  = dma_en_q;
    assign bus.rw         = rw_q;
    assign bus.dmaAddress = addr_q;
    assign bus.dmaData    = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_store_block.sv
// tb_store_block
//   Scoreboard bench for store_block: each scenario pushes the expected
//   (address, data) stream when it starts a transfer and pops one entry for
//   every DMA write the DUT produces.
module tb_store_block;
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   chk = 0;
    int   err = 0;
    exp_t exp_q[$];
    logic [15:0] mem [1024];

    store_block_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_WORDS(1024)) bus ();

    store_block #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_mem(input logic [15:0] seed, input logic [15:0] stride);
        for (int i = 0; i < 1024; i++) begin
            mem[i] = seed + 16'(i) * stride;
            bus.blockIn[i*16 +: 16] = mem[i];
        end
    endtask

    task automatic push_expected(input logic [15:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = base + 16'(i);
            e.data = mem[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        int pulses = 0;
        reset = 1'b0;
        bus.enable = 1'b1;
        bus.size = 16'd6;
        bus.address = 16'h0100;
        repeat (2) begin
            step();
            if (bus.dmaEnable === 1'b1) pulses++;
        end
        chk++;
        if ({bus.dmaEnable, bus.rw, bus.dmaAddress, bus.dmaData, bus.busy, bus.done} !==
            {1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            err++;
            $display("FAIL reset_outputs: got en=%b rw=%b addr=%h data=%h busy=%b done=%b, want 0 1 0000 0000 0 0",
                     bus.dmaEnable, bus.rw, bus.dmaAddress, bus.dmaData, bus.busy, bus.done);
        end
        chk++;
        if (pulses !== 0) begin
            err++;
            $display("FAIL reset_no_pulse: got %0d dmaEnable cycles, want 0", pulses);
        end
        bus.enable = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        exp_t e;
        int s, nwr = 0, first = -1, last = -1, done_at = -1, stray = 0;
        load_mem(16'hA000, 16'd1);
        bus.enable = 1'b1;
        bus.size = 16'd6;
        bus.address = 16'h0100;
        s = cyc;
        push_expected(16'h0100, 36);
        for (int k = 0; k < 60; k++) begin
            step();
            if (k == 1) begin
                // latched at start: later changes must not matter
                bus.size = 16'd2;
                bus.address = 16'h0000;
            end
            if (bus.dmaEnable === 1'b1) begin
                nwr++;
                if (first < 0) first = cyc;
                last = cyc;
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL basic_extra_write: got addr=%h data=%h, want no write", bus.dmaAddress, bus.dmaData);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rw, bus.dmaAddress, bus.dmaData} !== {1'b0, e.addr, e.data}) begin
                        err++;
                        $display("FAIL basic_write: got rw=%b addr=%h data=%h, want rw=0 addr=%h data=%h",
                                 bus.rw, bus.dmaAddress, bus.dmaData, e.addr, e.data);
                    end
                end
            end
            if (bus.done === 1'b1) begin
                done_at = cyc;
                break;
            end
        end
        chk++;
        if (first !== s + 1) begin
            err++;
            $display("FAIL basic_latency: got first write at cycle %0d, want %0d", first - s, 1);
        end
        chk++;
        if (nwr !== 36 || last - first !== 35 || exp_q.size() != 0) begin
            err++;
            $display("FAIL basic_count: got %0d writes over %0d cycles, %0d left, want 36 over 36, 0 left",
                     nwr, last - first + 1, exp_q.size());
        end
        chk++;
        if (done_at !== s + 37 || bus.busy !== 1'b0 || bus.rw !== 1'b1) begin
            err++;
            $display("FAIL basic_done: got done at +%0d busy=%b rw=%b, want +37 busy=0 rw=1", done_at - s, bus.busy, bus.rw);
        end
        repeat (3) begin
            step();
            if (bus.dmaEnable === 1'b1) stray++;
        end
        chk++;
        if (bus.done !== 1'b1 || stray !== 0) begin
            err++;
            $display("FAIL basic_done_hold: got done=%b stray=%0d, want done=1 stray=0", bus.done, stray);
        end
        bus.enable = 1'b0;
        step();
        chk++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            err++;
            $display("FAIL basic_done_clear: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_zero();
        bus.enable = 1'b1;
        bus.size = 16'd0;
        bus.address = 16'h0500;
        step();
        chk++;
        if ({bus.dmaEnable, bus.busy, bus.done} !== 3'b010) begin
            err++;
            $display("FAIL zero_first: got en=%b busy=%b done=%b, want 0 1 0", bus.dmaEnable, bus.busy, bus.done);
        end
        step();
        chk++;
        if ({bus.dmaEnable, bus.busy, bus.done} !== 3'b001) begin
            err++;
            $display("FAIL zero_done: got en=%b busy=%b done=%b, want 0 0 1", bus.dmaEnable, bus.busy, bus.done);
        end
        bus.enable = 1'b0;
        step();
        chk++;
        if (bus.done !== 1'b0) begin
            err++;
            $display("FAIL zero_clear: got done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int s, nwr = 0, first = -1, last = -1, done_at = -1;
        load_mem(16'h0000, 16'd1);
        bus.enable = 1'b1;
        bus.size = 16'd3;
        bus.address = 16'hFFFE;
        s = cyc;
        push_expected(16'hFFFE, 9);
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.dmaEnable === 1'b1) begin
                nwr++;
                if (first < 0) first = cyc;
                last = cyc;
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL wrap_extra_write: got addr=%h data=%h, want no write", bus.dmaAddress, bus.dmaData);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rw, bus.dmaAddress, bus.dmaData} !== {1'b0, e.addr, e.data}) begin
                        err++;
                        $display("FAIL wrap_write: got rw=%b addr=%h data=%h, want rw=0 addr=%h data=%h",
                                 bus.rw, bus.dmaAddress, bus.dmaData, e.addr, e.data);
                    end
                end
            end
            if (bus.done === 1'b1) begin
                done_at = cyc;
                break;
            end
        end
        chk++;
        if (nwr !== 9 || first !== s + 1 || last - first !== 8 || done_at !== s + 10) begin
            err++;
            $display("FAIL wrap_count: got %0d writes first=+%0d span=%0d done=+%0d, want 9 +1 9 +10",
                     nwr, first - s, last - first + 1, done_at - s);
        end
        bus.enable = 1'b0;
        step();
    endtask

    task automatic test_saturate();
        exp_t e;
        int s, nwr = 0, first = -1, last = -1, done_at = -1;
        logic [15:0] last_addr = 16'h0;
        load_mem(16'h1357, 16'd3);
        bus.enable = 1'b1;
        bus.size = 16'd40;
        bus.address = 16'h2000;
        s = cyc;
        push_expected(16'h2000, 1024);
        for (int k = 0; k < 1100; k++) begin
            step();
            if (bus.dmaEnable === 1'b1) begin
                nwr++;
                if (first < 0) first = cyc;
                last = cyc;
                last_addr = bus.dmaAddress;
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL sat_extra_write: got addr=%h data=%h, want no write", bus.dmaAddress, bus.dmaData);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rw, bus.dmaAddress, bus.dmaData} !== {1'b0, e.addr, e.data}) begin
                        err++;
                        $display("FAIL sat_write: got rw=%b addr=%h data=%h, want rw=0 addr=%h data=%h",
                                 bus.rw, bus.dmaAddress, bus.dmaData, e.addr, e.data);
                    end
                end
            end
            if (bus.done === 1'b1) begin
                done_at = cyc;
                break;
            end
        end
        chk++;
        if (nwr !== 1024 || last - first !== 1023 || done_at !== s + 1025 || last_addr !== 16'h23FF) begin
            err++;
            $display("FAIL sat_count: got %0d writes span=%0d done=+%0d last=%h, want 1024 1024 +1025 23ff",
                     nwr, last - first + 1, done_at - s, last_addr);
        end
        bus.enable = 1'b0;
        step();
    endtask

    task automatic test_abort();
        exp_t e;
        int nwr = 0;
        load_mem(16'h4000, 16'd7);
        bus.enable = 1'b1;
        bus.size = 16'd5;
        bus.address = 16'h0300;
        push_expected(16'h0300, 25);
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 1) bus.enable = 1'b0;
            if (bus.dmaEnable === 1'b1) begin
                nwr++;
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL abort_extra_write: got addr=%h data=%h, want no write", bus.dmaAddress, bus.dmaData);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rw, bus.dmaAddress, bus.dmaData} !== {1'b0, e.addr, e.data}) begin
                        err++;
                        $display("FAIL abort_write: got rw=%b addr=%h data=%h, want rw=0 addr=%h data=%h",
                                 bus.rw, bus.dmaAddress, bus.dmaData, e.addr, e.data);
                    end
                end
            end
            if (nwr == 10) break;
        end
        chk++;
        if (nwr !== 10) begin
            err++;
            $display("FAIL abort_before_reset: got %0d writes, want 10", nwr);
        end
        reset = 1'b0;
        step();
        chk++;
        if ({bus.dmaEnable, bus.rw, bus.busy, bus.done} !== 4'b0100) begin
            err++;
            $display("FAIL abort_reset_outputs: got en=%b rw=%b busy=%b done=%b, want 0 1 0 0",
                     bus.dmaEnable, bus.rw, bus.busy, bus.done);
        end
        step();
        reset = 1'b1;
        repeat (6) begin
            step();
            if (bus.dmaEnable === 1'b1) nwr++;
        end
        chk++;
        if (nwr !== 10 || exp_q.size() != 15) begin
            err++;
            $display("FAIL abort_no_more_writes: got %0d writes, %0d unissued, want 10 and 15", nwr, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.size = 16'd0;
        bus.address = 16'h0;
        bus.blockIn = '0;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_saturate();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule

// File: doc/store_block.md
Name: store_block

Overview:
- Writes a square block of 16-bit results (size x size words, row-major) from a local result buffer back to memory through the DMA write port.
- It is the write-side counterpart of load_block, which reads blocks from memory through the DMA read port.
- It sits between the convolution/pooling datapath output buffer and DMA.
- It issues one DMA write per cycle, then signals done.

Parameters:
- DATA_WIDTH, 16: width of a data word and of the DMA data bus.
- ADDR_WIDTH, 16: width of DMA addresses.
- MAX_WORDS, 1024: capacity of the result buffer. It is also the maximum number of words written per block.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  start request. It is sampled in IDLE.
- size  input  16  block edge length in words. The block holds size*size words.
- address  input  ADDR_WIDTH  base memory address of word 0.
- blockIn  input  MAX_WORDS*DATA_WIDTH  flattened result buffer. Word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- dmaEnable  output  1  DMA access strobe. One word is written per cycle while high.
- rw  output  1  DMA direction. 1 means read and 0 means write. This block drives 0 whenever dmaEnable is 1.
- dmaAddress  output  ADDR_WIDTH  DMA write address.
- dmaData  output  DATA_WIDTH  DMA write data.
- busy  output  1  high from acceptance of a request until done asserts.
- done  output  1  completion flag. It is held until enable is deasserted.

Behaviour:
- Reset (reset==0 at a rising edge): the FSM goes to IDLE. Resulting output values:
  - dmaEnable=0, rw=1 (safe read direction)
  - dmaAddress=0, dmaData=0
  - busy=0, done=0
  - the internal index and word count clear
- Reset mid-operation aborts the transfer immediately. No further writes are issued.
- States are IDLE, WRITE and DONE. All outputs are registered.
- IDLE:
  - On enable==1 the block latches base=address.
  - It latches total=size*size as a 32-bit product, saturated to MAX_WORDS.
  - It sets idx=0 and busy=1.
  - If total==0, it goes directly to DONE (done=1 on the next cycle, no DMA writes).
  - Otherwise it goes to WRITE.
- WRITE:
  - Each cycle drives dmaEnable=1, rw=0, dmaAddress=base+idx (modulo 2^ADDR_WIDTH, so the address wraps silently) and dmaData=blockIn word idx.
  - idx then increments.
  - When idx==total-1 has been issued, the next state is DONE.
- Timing:
  - The first write appears on the outputs in the cycle after enable is sampled high (latency 1).
  - Words are issued back to back with no gaps.
  - The transfer takes exactly total cycles of dmaEnable=1.
- DONE:
  - dmaEnable=0, rw=1, busy=0, done=1.
  - done stays 1 while enable==1.
  - When enable==0 the block returns to IDLE with done=0 on the next edge.
  - A new request therefore requires enable to drop and rise again. This prevents double writes when enable is held as a level.
- During WRITE, the enable, size and address inputs are ignored; they were latched at start. enable deassertion does not abort the transfer.
- blockIn must remain stable while busy==1. It is not captured.
- Sizes above 32 saturate to MAX_WORDS (1024) words. The block never indexes beyond blockIn.
- rw is 1 in every state except WRITE. The block never writes when dmaEnable==0.

Test Plan:
1. reset=0 for 2 cycles while enable=1 and size=6 -> all outputs are at their reset values; no dmaEnable pulse.
2. size=6, address=0x0100, blockIn word i = i+0xA000, enable pulsed high then held:
   - exactly 36 consecutive cycles of dmaEnable=1, rw=0;
   - addresses run 0x0100..0x0123 and data 0xA000..0xA023;
   - the first write comes 1 cycle after enable is sampled;
   - then done=1 and busy=0, held while enable=1, cleared 1 cycle after enable=0.
3. size=0, enable=1 -> no DMA writes; done=1 two cycles after enable is sampled.
4. size=3, address=0xFFFE, enable=1 -> 9 writes at addresses 0xFFFE, 0xFFFF, 0x0000..0x0006 (wrap), data words 0..8.
5. size=40 -> exactly 1024 writes (saturation), last address base+1023.
6. size=5 with enable dropped after cycle 2, then reset=0 asserted at write #10:
   - the early enable drop does not stop the transfer (writes 0..9 occur);
   - after reset, dmaEnable=0 and rw=1 on the next edge; no further writes.
